instr_issue: RTL and testbench
==============================

INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 256, program memory depth in 9-bit words, indexed by an 8-bit PC.
REQ-002 SHALL provide parameter HALT_OPCODE, default 5'b11111, opcode value in INSTR[8:4] that marks end of program.
REQ-003 SHALL use one clock and synchronous, active-high reset: CLK  in  1  rising-edge clock; RESET  in  1  synchronous active-high reset.
REQ-004 SHALL provide START  in  1  begin issuing at START_ADDRESS.
REQ-005 SHALL provide START_ADDRESS  in  8  first PC value.
REQ-006 SHALL provide LOAD_EN  in  1  program-memory write strobe.
REQ-007 SHALL provide LOAD_ADDR  in  8  program-memory write address.
REQ-008 SHALL provide LOAD_DATA  in  9  program-memory write word.
REQ-009 SHALL provide BRANCH_TAKEN  in  1  redirect PC on the current handshake.
REQ-010 SHALL provide TARGET_IN  in  8  branch target PC.
REQ-011 SHALL provide INSTR_READY  in  1  consumer (fetch/decode stage) accepts INSTR.
REQ-012 SHALL provide INSTR  out  9  issued instruction word.
REQ-013 SHALL provide INSTR_VALID  out  1  INSTR is valid.
REQ-014 SHALL provide PC  out  8  address of the word in INSTR, or of the next word to fetch.
REQ-015 SHALL provide DONE  out  1  program finished.

Function
REQ-016 SHALL implement states IDLE, FETCH, ISSUE, HALTED; only ISSUE drives INSTR_VALID=1.
REQ-017 IDLE: on START=1, SHALL load PC<=START_ADDRESS and go to FETCH; otherwise stay.
REQ-018 FETCH: SHALL read mem[PC] synchronously (1-cycle latency), register it into INSTR and go to ISSUE next cycle.
REQ-019 ISSUE: SHALL hold INSTR, PC and INSTR_VALID stable while INSTR_READY=0.
REQ-020 Handshake (INSTR_VALID&INSTR_READY): SHALL set PC<=TARGET_IN if BRANCH_TAKEN=1, else PC<=PC+1 mod 256 (255 wraps to 0), then go to FETCH.
REQ-021 Throughput SHALL be one instruction per two cycles with INSTR_READY held high; START-to-first-INSTR_VALID latency SHALL be 2 cycles.
REQ-022 BRANCH_TAKEN and TARGET_IN SHALL be ignored in any cycle without a handshake.
REQ-023 LOAD_EN SHALL write mem[LOAD_ADDR]<=LOAD_DATA only in IDLE or HALTED; writes in FETCH/ISSUE SHALL be dropped.
REQ-024 LOAD_EN and START in the same IDLE cycle SHALL both take effect; the following FETCH SHALL return the newly written word if LOAD_ADDR==START_ADDRESS.
REQ-025 START SHALL be ignored in FETCH and ISSUE.
REQ-026 HALTED: DONE=1, INSTR_VALID=0; START=1 SHALL clear DONE, load PC<=START_ADDRESS, and go to FETCH.

Reset
REQ-027 RESET=1 at any clock edge SHALL force state IDLE, PC=0, INSTR=0, INSTR_VALID=0, DONE=0, regardless of state or concurrent START/LOAD_EN.
REQ-028 RESET SHALL NOT clear program memory contents.
REQ-029 An in-flight instruction interrupted by RESET SHALL be discarded, with no handshake reported.

Configuration
REQ-030 Macro INSTR_ISSUE_HALT_DETECT_EN defined: a handshake on a word with INSTR[8:4]==HALT_OPCODE SHALL go to HALTED (PC not advanced) instead of FETCH.
REQ-031 Macro INSTR_ISSUE_HALT_DETECT_EN undefined: HALT_OPCODE words SHALL be issued like any other, HALTED SHALL be unreachable, and DONE SHALL be constant 0.

Verification
REQ-032 Load mem[0..2]={9'h011,9'h022,9'h033}, START with START_ADDRESS=0, INSTR_READY=1 -> INSTR 011,022,033 on cycles 2,4,6 after START; PC 0,1,2.
REQ-033 At mem[5]=9'h0A5, hold INSTR_READY=0 for 4 cycles -> INSTR=0A5, PC=5, INSTR_VALID=1 held stable; advances to PC=6 one cycle after READY rises.
REQ-034 Handshake at PC=3 with BRANCH_TAKEN=1, TARGET_IN=8'h40 -> next issued PC=8'h40 with mem[0x40]; BRANCH_TAKEN pulsed while READY=0 -> no redirect.
REQ-035 START_ADDRESS=8'hFF, run 2 instructions -> PC sequence FF then 00 (wrap).
REQ-036 With macro defined, mem[2]={5'b11111,4'h0} -> DONE=1, INSTR_VALID=0, PC=2 after its handshake; macro undefined -> issue continues at PC=3, DONE=0.
REQ-037 RESET asserted during ISSUE with LOAD_EN=1 -> next cycle IDLE, all outputs zero, LOAD write dropped, memory otherwise unchanged.

Source files
------------

// File: rtl/instr_issue_if.sv
// instr_issue_if -- issue-side handshake bundle between the instruction
// issuer and its consumer (fetch/decode stage).
//
//   instr        [8:0]  issued instruction word
//   instr_valid         instr holds a word waiting to be accepted
//   pc           [7:0]  address of the word in instr, or next address to fetch
//   instr_ready         consumer accepts instr this cycle
//   branch_taken        redirect on the current handshake
//   target_in    [7:0]  redirect address
//
// master: the issuer. slave: the consumer.
interface instr_issue_if;
    logic [8:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic       instr_ready;
    logic       branch_taken;
    logic [7:0] target_in;

    modport master (
        output instr, instr_valid, pc,
        input  instr_ready, branch_taken, target_in
    );

    modport slave (
        input  instr, instr_valid, pc,
        output instr_ready, branch_taken, target_in
    );
endinterface

// File: rtl/instr_issue.sv
// instr_issue -- walks a small loadable program memory and issues one
// 9-bit word per valid/ready handshake, with optional branch redirect.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-high reset (memory contents kept)
//   start                begin issuing at start_address (from IDLE or HALTED)
//   start_address [7:0]  first PC value
//   load_en              program-memory write strobe (IDLE/HALTED only)
//   load_addr     [7:0]  program-memory write address
//   load_data     [8:0]  program-memory write word
//   done                 program reached a halt word
//   bus                  instr_issue_if.master issue handshake
//
// Build option: define INSTR_ISSUE_HALT_DETECT_EN to stop on a word whose
// opcode field [8:4] equals HALT_OPCODE. Without it, halt words are issued
// like any other and done stays 0.
//
// state  | meaning
// IDLE   | waiting for start, program loads allowed
// FETCH  | reading mem[pc]; result registered into instr
// ISSUE  | instr_valid high, waiting for instr_ready
// HALTED | halt word accepted, done high, loads allowed
module instr_issue #(
    parameter int         MEM_DEPTH   = 256,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_address,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [8:0]  load_data,
    output logic        done,
    instr_issue_if.master bus
);

`ifdef INSTR_ISSUE_HALT_DETECT_EN
    localparam bit HALT_DETECT = 1'b1;
`else
    localparam bit HALT_DETECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] pc_q;
    logic [8:0] instr_q;
    logic       valid_q;
    logic       done_q;

    logic [8:0] mem [MEM_DEPTH];

    logic load_ok;
    logic handshake;
    logic halt_hit;

    // Writes are only honoured while nothing is in flight, and never on a
    // reset edge. Memory itself has no reset.
    assign load_ok   = load_en && !reset && (state == IDLE || state == HALTED);
    assign handshake = (state == ISSUE) && bus.instr_ready;
    assign halt_hit  = HALT_DETECT && (instr_q[8:4] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= 8'd0;
            instr_q <= 9'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pc_q  <= start_address;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // A load in the preceding IDLE cycle has already landed,
                    // so a same-cycle load+start reads the new word here.
                    instr_q <= mem[pc_q];
                    valid_q <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (halt_hit) begin
                            // PC stays on the halt word.
                            done_q <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc_q  <= bus.branch_taken ? bus.target_in : pc_q + 8'd1;
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    if (start) begin
                        done_q <= 1'b0;
                        pc_q   <= start_address;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign done            = done_q;

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_address;
    logic       load_en;
    logic [7:0] load_addr;
    logic [8:0] load_data;
    logic       done;

    instr_issue_if bus();

    instr_issue dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_address(start_address),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] HALT_OP = 5'b11111;
`ifdef INSTR_ISSUE_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] pc;
        logic [8:0] instr;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] mref [256];
    exp_t       expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per handshake, and checks that a
    // stalled word stays put.
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_reset = 1'b1;
    logic [8:0] p_instr = 9'd0;
    logic [7:0] p_pc    = 8'd0;
    exp_t       m_e;

    always @(negedge clk) begin
        if (p_valid && !p_ready && !p_reset) begin
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_instr", 32'(bus.instr), 32'(p_instr));
            check("stall_pc",    32'(bus.pc),    32'(p_pc));
        end
        if (bus.instr_valid && bus.instr_ready && !reset) begin
            if (expq.size() == 0) begin
                check("unexpected_handshake", 32'd1, 32'd0);
            end else begin
                m_e = expq.pop_front();
                check("hs_pc",    32'(bus.pc),    32'(m_e.pc));
                check("hs_instr", 32'(bus.instr), 32'(m_e.instr));
            end
        end
        p_valid = bus.instr_valid;
        p_ready = bus.instr_ready;
        p_reset = reset;
        p_instr = bus.instr;
        p_pc    = bus.pc;
    end

    task automatic do_reset;
        reset            = 1'b1;
        start            = 1'b0;
        load_en          = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick;
        load_en = 1'b0;
        mref[a] = d;
    endtask

    // Activity that must have no effect while a word is in flight.
    task automatic noise(input bit rnd);
        if (rnd) begin
            start         = 1'($urandom);
            start_address = 8'($urandom);
            load_en       = 1'($urandom);
            load_addr     = 8'($urandom);
            load_data     = 9'($urandom);
        end else begin
            start   = 1'b0;
            load_en = 1'b0;
        end
    endtask

    // Issue n words starting at sa. Program order: next = branch ? target : pc+1.
    task automatic run_prog(input logic [7:0] sa, input int n, input bit rnd,
                            input int fix_stall, input int br_idx, input logic [7:0] br_tgt,
                            input bit ld, input logic [8:0] ld_data);
        logic [7:0] pc;
        int         s;
        bit         b;
        logic [7:0] t;
        start         = 1'b1;
        start_address = sa;
        if (ld) begin
            load_en   = 1'b1;
            load_addr = sa;
            load_data = ld_data;
            mref[sa]  = ld_data;
        end
        tick;
        start   = 1'b0;
        load_en = 1'b0;
        pc      = sa;
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                s = int'($urandom_range(0, 3));
                b = ($urandom_range(0, 3) == 0);
                t = 8'($urandom);
            end else begin
                s = fix_stall;
                b = (k == br_idx);
                t = br_tgt;
            end
            expq.push_back(exp_t'({pc, mref[pc]}));
            check("fetch_valid", 32'(bus.instr_valid), 32'd0);
            noise(rnd);
            bus.instr_ready  = rnd ? 1'($urandom) : 1'b0;
            bus.branch_taken = 1'b1;
            bus.target_in    = 8'($urandom);
            tick;
            for (int j = 0; j < s; j++) begin
                noise(rnd);
                bus.instr_ready  = 1'b0;
                bus.branch_taken = 1'b1;
                bus.target_in    = 8'($urandom);
                tick;
            end
            check("issue_valid", 32'(bus.instr_valid), 32'd1);
            bus.instr_ready  = 1'b1;
            bus.branch_taken = b;
            bus.target_in    = t;
            tick;
            bus.instr_ready  = 1'b0;
            bus.branch_taken = 1'b0;
            start            = 1'b0;
            load_en          = 1'b0;
            if (HALT_EN && mref[pc][8:4] == HALT_OP) break;
            pc = b ? t : pc + 8'd1;
        end
    endtask

    logic [8:0] old_word;

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        start_address    = 8'd0;
        load_en          = 1'b0;
        load_addr        = 8'd0;
        load_data        = 9'd0;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target_in    = 8'd0;
        tick;
        tick;
        check("rst_pc",    32'(bus.pc),          32'd0);
        check("rst_instr", 32'(bus.instr),       32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_done",  32'(done),            32'd0);
        reset = 1'b0;

        for (int a = 0; a < 256; a++) load_word(8'(a), 9'($urandom_range(0, 9'h1EF)));
        load_word(8'd0, 9'h011);
        load_word(8'd1, 9'h022);
        load_word(8'd2, 9'h033);
        load_word(8'd5, 9'h0A5);

        run_prog(8'd0, 3, 1'b0, 0, -1, 8'd0, 1'b0, 9'd0);       // back-to-back
        do_reset;
        run_prog(8'd5, 2, 1'b0, 4, -1, 8'd0, 1'b0, 9'd0);       // 4-cycle stall
        do_reset;
        run_prog(8'd3, 2, 1'b0, 1, 0, 8'h40, 1'b0, 9'd0);       // branch to 0x40
        do_reset;
        run_prog(8'hFF, 2, 1'b0, 0, -1, 8'd0, 1'b0, 9'd0);      // wrap
        do_reset;
        run_prog(8'h10, 1, 1'b0, 0, -1, 8'd0, 1'b1, 9'h155);    // load+start same cycle
        do_reset;

        // Reset while a word is on offer, with a concurrent load.
        old_word      = mref[8'h20];
        start         = 1'b1;
        start_address = 8'h20;
        tick;
        start = 1'b0;
        tick;
        check("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        reset     = 1'b1;
        load_en   = 1'b1;
        load_addr = 8'h20;
        load_data = ~old_word;
        tick;
        reset   = 1'b0;
        load_en = 1'b0;
        check("midrst_pc",    32'(bus.pc),          32'd0);
        check("midrst_instr", 32'(bus.instr),       32'd0);
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_done",  32'(done),            32'd0);
        run_prog(8'h20, 1, 1'b0, 0, -1, 8'd0, 1'b0, 9'd0);     // expects old word
        do_reset;

        // Halt word at address 2.
        load_word(8'd2, {HALT_OP, 4'h0});
        run_prog(8'd0, 4, 1'b0, 0, -1, 8'd0, 1'b0, 9'd0);
`ifdef INSTR_ISSUE_HALT_DETECT_EN
        check("halt_done",  32'(done),            32'd1);
        check("halt_valid", 32'(bus.instr_valid), 32'd0);
        check("halt_pc",    32'(bus.pc),          32'd2);
        tick;
        tick;
        check("halt_hold_done", 32'(done), 32'd1);
        run_prog(8'h30, 2, 1'b0, 0, -1, 8'd0, 1'b0, 9'd0);  // restart from HALTED
        check("restart_done", 32'(done), 32'd0);
`else
        check("nohalt_done", 32'(done), 32'd0);
`endif
        do_reset;
        load_word(8'd2, 9'h033);

        for (int r = 0; r < 6; r++) begin
            run_prog(8'($urandom), 20, 1'b1, 0, -1, 8'd0, 1'b0, 9'd0);
            do_reset;
        end

        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
